// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types for the dds sweep sequencer: FSM state encoding and sweep mode codes.
package dds_sweep_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN_UP   = 2'd1,
      ST_RUN_DOWN = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'b00,
      MODE_SAW    = 2'b01,
      MODE_TRI    = 2'b10
   } mode_e;

   // Mode code 2'b11 is an alias of single.
   function automatic mode_e decode_mode(input logic [1:0] code);
      mode_e m;
      case (code)
         2'b01:   m = MODE_SAW;
         2'b10:   m = MODE_TRI;
         default: m = MODE_SINGLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: loads a (dwell-1) period, counts down while enabled, flags the last cycle of each dwell.
module dds_dwell_timer #(
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               load,
   input  logic               en,
   input  logic [DWELL_W-1:0] period,
   output logic               expire_c
);

   logic [DWELL_W-1:0] period_q;
   logic [DWELL_W-1:0] cnt;

   // Auto-reloads on expiry so every dwell lasts exactly period+1 cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         period_q <= '0;
         cnt      <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         period_q <= period;
         cnt      <= period;
      end else if (en) begin
         cnt <= (cnt == '0) ? period_q : cnt - DWELL_W'(1);
      end
   end

   assign expire_c = en && (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving dds freq/phase/amplitude inputs from a start/stop/step/dwell program.
module dds_sweep_ctrl
   import dds_sweep_ctrl_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         cfg_mode,
   input  logic [N:0]         cfg_f_start,
   input  logic [N:0]         cfg_f_stop,
   input  logic [N:0]         cfg_f_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [N:0]         cfg_phase,
   input  logic [N:0]         cfg_amp,
   output logic [N:0]         freq_out,
   output logic [N:0]         phase_out,
   output logic [N:0]         amp_out,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   localparam int unsigned W = N + 1;

   state_e         state;
   mode_e          mode_q;
   logic [W-1:0]   f_start_q;
   logic [W-1:0]   f_stop_q;
   logic [W-1:0]   f_step_q;

   logic               running_c;
   logic               accept_c;
   logic               expire_c;
   logic [DWELL_W-1:0] period_c;
   logic [W:0]         sum_c;
   logic [W:0]         diff_c;
   logic [W-1:0]       up_c;
   logic [W-1:0]       down_c;
   logic               at_top_c;
   logic               at_bottom_c;
   logic               degenerate_c;

   // Clamped add/sub datapath; the extra bit catches carry-out and borrow.
   always_comb begin
      running_c    = (state == ST_RUN_UP) || (state == ST_RUN_DOWN);
      accept_c     = start && !abort && (state == ST_IDLE);
      period_c     = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
      sum_c        = {1'b0, freq_out} + {1'b0, f_step_q};
      diff_c       = {1'b0, freq_out} - {1'b0, f_step_q};
      up_c         = (sum_c > {1'b0, f_stop_q}) ? f_stop_q : sum_c[W-1:0];
      down_c       = (diff_c[W] || (diff_c[W-1:0] < f_start_q)) ? f_start_q : diff_c[W-1:0];
      degenerate_c = (f_start_q >= f_stop_q) || (f_step_q == '0);
      at_top_c     = (freq_out >= f_stop_q) || (f_step_q == '0);
      at_bottom_c  = (freq_out <= f_start_q);
   end

   dds_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell (
      .clock    (clock),
      .reset    (reset),
      .clear    (abort),
      .load     (accept_c),
      .en       (running_c),
      .period   (period_c),
      .expire_c (expire_c)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_SINGLE;
         f_start_q <= '0;
         f_stop_q  <= '0;
         f_step_q  <= '0;
         freq_out  <= '0;
         phase_out <= '0;
         amp_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         if (abort) begin
            state     <= ST_IDLE;
            freq_out  <= '0;
            phase_out <= '0;
            amp_out   <= '0;
            busy      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state     <= ST_RUN_UP;
                     mode_q    <= decode_mode(cfg_mode);
                     f_start_q <= cfg_f_start;
                     f_stop_q  <= cfg_f_stop;
                     f_step_q  <= cfg_f_step;
                     freq_out  <= cfg_f_start;
                     phase_out <= cfg_phase;
                     amp_out   <= cfg_amp;
                     busy      <= 1'b1;
                  end
               end
               ST_RUN_UP: begin
                  if (expire_c) begin
                     if (at_top_c) begin
                        case (mode_q)
                           MODE_SAW: begin
                              freq_out <= f_start_q;
                              wrap     <= 1'b1;
                           end
                           MODE_TRI: begin
                              // A degenerate triangle has nowhere to turn; it just re-holds f_start.
                              if (degenerate_c) begin
                                 freq_out <= f_start_q;
                                 wrap     <= 1'b1;
                              end else begin
                                 state    <= ST_RUN_DOWN;
                                 freq_out <= down_c;
                              end
                           end
                           default: begin
                              state     <= ST_DONE;
                              done      <= 1'b1;
                              busy      <= 1'b0;
                              freq_out  <= '0;
                              phase_out <= '0;
                              amp_out   <= '0;
                           end
                        endcase
                     end else begin
                        freq_out <= up_c;
                     end
                  end
               end
               ST_RUN_DOWN: begin
                  if (expire_c) begin
                     if (at_bottom_c) begin
                        state    <= ST_RUN_UP;
                        wrap     <= 1'b1;
                        freq_out <= up_c;
                     end else begin
                        freq_out <= down_c;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a sweep-list model predicts every output each cycle.
module tb_dds_sweep_ctrl;

   localparam int unsigned N  = 8;
   localparam int unsigned W  = N + 1;
   localparam int unsigned DW = 16;

   logic          clock;
   logic          reset;
   logic          start;
   logic          abort;
   logic [1:0]    cfg_mode;
   logic [W-1:0]  cfg_f_start;
   logic [W-1:0]  cfg_f_stop;
   logic [W-1:0]  cfg_f_step;
   logic [DW-1:0] cfg_dwell;
   logic [W-1:0]  cfg_phase;
   logic [W-1:0]  cfg_amp;
   logic [W-1:0]  freq_out;
   logic [W-1:0]  phase_out;
   logic [W-1:0]  amp_out;
   logic          busy;
   logic          done;
   logic          wrap;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int freq;
      int phase;
      int amp;
      int busy;
      int done;
      int wrap;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   exp_t zero_e = '{default: 0};

   dds_sweep_ctrl #(.N(N), .DWELL_W(DW)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .cfg_mode    (cfg_mode),
      .cfg_f_start (cfg_f_start),
      .cfg_f_stop  (cfg_f_stop),
      .cfg_f_step  (cfg_f_step),
      .cfg_dwell   (cfg_dwell),
      .cfg_phase   (cfg_phase),
      .cfg_amp     (cfg_amp),
      .freq_out    (freq_out),
      .phase_out   (phase_out),
      .amp_out     (amp_out),
      .busy        (busy),
      .done        (done),
      .wrap        (wrap)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One frequency step: the value is held d cycles; wrap marks only the first of them.
   function automatic void push_step(input int v, input int d, input int ph, input int am, input bit wr);
      for (int c = 0; c < d; c++) begin
         exp_t e;
         e.freq  = v;
         e.phase = ph;
         e.amp   = am;
         e.busy  = 1;
         e.done  = 0;
         e.wrap  = (wr && c == 0) ? 1 : 0;
         q.push_back(e);
      end
   endfunction

   // Expand a sweep program into the per-cycle output sequence it must produce.
   function automatic void build(input int mode, input int fs, input int fe, input int st,
                                 input int dw, input int ph, input int am);
      int d;
      int v;
      int up[$];
      int dn[$];
      bit degen;
      exp_t e;
      d     = (dw == 0) ? 1 : dw;
      degen = (fs >= fe) || (st == 0);
      up.push_back(fs);
      if (!degen) begin
         v = fs;
         while (v < fe) begin
            v = v + st;
            if (v > fe) v = fe;
            up.push_back(v);
         end
      end
      if (mode == 1 || (mode == 2 && degen)) begin
         foreach (up[i]) push_step(up[i], d, ph, am, 1'b0);
         while (q.size() < 600) begin
            foreach (up[i]) push_step(up[i], d, ph, am, i == 0);
         end
      end else if (mode == 2) begin
         v = fe;
         while (v > fs) begin
            v = v - st;
            if (v < fs) v = fs;
            dn.push_back(v);
         end
         foreach (up[i]) push_step(up[i], d, ph, am, 1'b0);
         foreach (dn[i]) push_step(dn[i], d, ph, am, 1'b0);
         while (q.size() < 600) begin
            for (int i = 1; i < up.size(); i++) push_step(up[i], d, ph, am, i == 1);
            foreach (dn[i]) push_step(dn[i], d, ph, am, 1'b0);
         end
      end else begin
         foreach (up[i]) push_step(up[i], d, ph, am, 1'b0);
         e      = zero_e;
         e.done = 1;
         q.push_back(e);
      end
   endfunction

   // Model advance: cur is what the outputs must show until the next rising edge.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q.delete();
         cur = zero_e;
      end else if (abort) begin
         q.delete();
         cur = zero_e;
      end else begin
         if (start && cur.busy == 0 && cur.done == 0)
            build(int'(cfg_mode), int'(cfg_f_start), int'(cfg_f_stop), int'(cfg_f_step),
                  int'(cfg_dwell), int'(cfg_phase), int'(cfg_amp));
         if (q.size() > 0) cur = q.pop_front();
         else cur = zero_e;
      end
   end

   always @(negedge clock) begin
      chk("freq_out",  int'(freq_out),  cur.freq);
      chk("phase_out", int'(phase_out), cur.phase);
      chk("amp_out",   int'(amp_out),   cur.amp);
      chk("busy",      int'(busy),      cur.busy);
      chk("done",      int'(done),      cur.done);
      chk("wrap",      int'(wrap),      cur.wrap);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_cfg(input int mode, input int fs, input int fe, input int st,
                          input int dw, input int ph, input int am);
      cfg_mode    = 2'(mode);
      cfg_f_start = W'(fs);
      cfg_f_stop  = W'(fe);
      cfg_f_step  = W'(st);
      cfg_dwell   = DW'(dw);
      cfg_phase   = W'(ph);
      cfg_amp     = W'(am);
   endtask

   // Returns at the first falling edge after the start edge.
   task automatic go(input int mode, input int fs, input int fe, input int st,
                     input int dw, input int ph, input int am);
      @(negedge clock);
      set_cfg(mode, fs, fe, st, dw, ph, am);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic do_abort;
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      cyc(3);
      chk("rst_freq", int'(freq_out), 0);
      chk("rst_amp",  int'(amp_out),  0);
      chk("rst_busy", int'(busy),     0);
      reset = 1'b1;
      cyc(2);

      // Single sweep 5..20 step 5, dwell 3
      go(0, 5, 20, 5, 3, 7, 100);
      chk("t1_f0", int'(freq_out), 5);
      chk("t1_ph", int'(phase_out), 7);
      chk("t1_amp", int'(amp_out), 100);
      chk("t1_busy", int'(busy), 1);
      cyc(2);  chk("t1_f0_end", int'(freq_out), 5);
      cyc(1);  chk("t1_f1", int'(freq_out), 10);
      cyc(8);  chk("t1_f3", int'(freq_out), 20);
      cyc(1);  chk("t1_done", int'(done), 1);
      chk("t1_amp_off", int'(amp_out), 0);
      cyc(1);  chk("t1_done_pulse", int'(done), 0);
      cyc(2);

      // Clamp at f_stop
      go(0, 250, 255, 4, 1, 0, 50);
      chk("t2_f0", int'(freq_out), 250);
      cyc(1); chk("t2_f1", int'(freq_out), 254);
      cyc(1); chk("t2_f2", int'(freq_out), 255);
      cyc(1); chk("t2_done", int'(done), 1);
      cyc(2);

      // Triangle, plus an ignored start with different cfg mid-run
      go(2, 10, 30, 10, 2, 3, 200);
      cyc(4); chk("t3_top", int'(freq_out), 30);
      cyc(2); chk("t3_down", int'(freq_out), 20);
      cyc(2); chk("t3_bottom", int'(freq_out), 10);
      chk("t3_bottom_wrap", int'(wrap), 0);
      cyc(2); chk("t3_turn", int'(freq_out), 20);
      chk("t3_turn_wrap", int'(wrap), 1);
      set_cfg(0, 99, 120, 7, 5, 1, 1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(6);
      do_abort;
      chk("t3_abort_busy", int'(busy), 0);
      cyc(2);

      // Sawtooth with abort
      go(1, 1, 3, 1, 1, 0, 10);
      chk("t4_f0", int'(freq_out), 1);
      cyc(2); chk("t4_f2", int'(freq_out), 3);
      cyc(1); chk("t4_restart", int'(freq_out), 1);
      chk("t4_wrap", int'(wrap), 1);
      cyc(2);
      do_abort;
      chk("t4_abort_busy", int'(busy), 0);
      chk("t4_abort_done", int'(done), 0);
      chk("t4_abort_amp", int'(amp_out), 0);
      cyc(3);

      // start and abort together
      @(negedge clock);
      set_cfg(0, 5, 20, 5, 1, 1, 1);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      chk("t5_sa_busy", int'(busy), 0);
      chk("t5_sa_freq", int'(freq_out), 0);
      cyc(2);

      // dwell 0 acts as 1; mode 11 acts as single
      go(3, 3, 5, 1, 0, 1, 1);
      chk("t5_d0_f0", int'(freq_out), 3);
      cyc(1); chk("t5_d0_f1", int'(freq_out), 4);
      cyc(1); chk("t5_d0_f2", int'(freq_out), 5);
      cyc(1); chk("t5_d0_done", int'(done), 1);
      cyc(2);

      // step 0 single
      go(0, 7, 20, 0, 2, 0, 9);
      chk("t5_s0_f0", int'(freq_out), 7);
      cyc(1); chk("t5_s0_f0b", int'(freq_out), 7);
      cyc(1); chk("t5_s0_done", int'(done), 1);
      cyc(2);

      // Degenerate sawtooth holds f_start, wrap each dwell
      go(1, 9, 4, 3, 2, 0, 5);
      chk("t5_dg_wrap0", int'(wrap), 0);
      cyc(2); chk("t5_dg_f", int'(freq_out), 9);
      chk("t5_dg_wrap1", int'(wrap), 1);
      cyc(4);
      do_abort;
      cyc(2);

      // Async reset between edges mid-sweep
      go(2, 10, 30, 10, 2, 3, 200);
      cyc(3);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_freq",  int'(freq_out),  0);
      chk("t6_rst_phase", int'(phase_out), 0);
      chk("t6_rst_amp",   int'(amp_out),   0);
      chk("t6_rst_busy",  int'(busy),      0);
      cyc(2);
      reset = 1'b1;
      cyc(1);
      go(0, 5, 20, 5, 3, 7, 100);
      chk("t6_f0", int'(freq_out), 5);
      cyc(12);
      chk("t6_done", int'(done), 1);
      cyc(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
